// File: rtl/rvv_commit_ctrl_if.sv
// Bundle of every non-clock signal between the scalar core, rvv_commit_ctrl and rvv_core.
// Signal suffixes are from the controller's point of view: the slave modport is the controller.
interface rvv_commit_ctrl_if #(
    parameter int IdWidth  = 3,
    parameter int CtxWidth = 16,
    parameter int XLen     = 64
);
    // scalar issue
    logic                up_valid_i;
    logic                up_ready_o;
    logic [31:0]         up_insn_i;
    logic [IdWidth-1:0]  up_insn_id_i;
    logic [CtxWidth-1:0] up_ctx_i;
    logic                up_resolved_i;
    // rvv_core issue
    logic                vec_valid_o;
    logic                vec_ready_i;
    logic [31:0]         vec_insn_o;
    logic [IdWidth-1:0]  vec_insn_id_o;
    logic [CtxWidth-1:0] vec_ctx_o;
    // speculation control
    logic                resolve_i;
    logic [IdWidth-1:0]  resolve_id_i;
    logic                flush_i;
    logic                flush_o;
    logic                can_commit_o;
    logic [IdWidth-1:0]  can_commit_id_o;
    // rvv_core completion
    logic                done_i;
    logic [IdWidth-1:0]  done_id_i;
    logic                done_illegal_i;
    logic [XLen-1:0]     done_result_i;
    // in-order retire
    logic                retire_valid_o;
    logic                retire_ready_i;
    logic [IdWidth-1:0]  retire_id_o;
    logic                retire_illegal_o;
    logic [XLen-1:0]     retire_result_o;
    logic                err_o;

    modport slave (
        input  up_valid_i, up_insn_i, up_insn_id_i, up_ctx_i, up_resolved_i,
        output up_ready_o,
        output vec_valid_o, vec_insn_o, vec_insn_id_o, vec_ctx_o,
        input  vec_ready_i,
        input  resolve_i, resolve_id_i, flush_i,
        output flush_o, can_commit_o, can_commit_id_o,
        input  done_i, done_id_i, done_illegal_i, done_result_i,
        output retire_valid_o, retire_id_o, retire_illegal_o, retire_result_o,
        input  retire_ready_i,
        output err_o
    );

    modport master (
        output up_valid_i, up_insn_i, up_insn_id_i, up_ctx_i, up_resolved_i,
        input  up_ready_o,
        input  vec_valid_o, vec_insn_o, vec_insn_id_o, vec_ctx_o,
        output vec_ready_i,
        output resolve_i, resolve_id_i, flush_i,
        input  flush_o, can_commit_o, can_commit_id_o,
        output done_i, done_id_i, done_illegal_i, done_result_i,
        input  retire_valid_o, retire_id_o, retire_illegal_o, retire_result_o,
        output retire_ready_i,
        input  err_o
    );
endinterface

// File: rtl/rvv_commit_ctrl.sv
// In-order outstanding table between the scalar core and rvv_core: forwards issue, drives
// program-order commit permission, handles flush, and reorders completions into in-order retires.
module rvv_commit_ctrl #(
    parameter int Depth    = 4,
    parameter int IdWidth  = 3,
    parameter int CtxWidth = 16,
    parameter int XLen     = 64
) (
    input logic              clk_i,
    input logic              rst_ni,
    rvv_commit_ctrl_if.slave bus
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    typedef logic [PtrW-1:0] ptr_t;

    logic [Depth-1:0]   valid_q, resolved_q, committed_q, done_q, illegal_q;
    logic [IdWidth-1:0] id_q     [Depth];
    logic [XLen-1:0]    result_q [Depth];

    ptr_t               head_q, cmt_q, tail_q;
    logic [CntW-1:0]    count_q, count_d, surv_cnt;
    logic               can_commit_q;
    logic [IdWidth-1:0] can_commit_id_q;
    logic               retire_valid_q;
    logic               err_q;

    logic               full, issue_ok, alloc, commit_fire, retire_fire, head_ready;
    logic [Depth-1:0]   res_match, done_match;
    logic               res_err, done_err;

    // Issue is a pure pass-through; the table only gates it when full or flushing.
    assign full     = (count_q == DepthCnt);
    assign issue_ok = ~full & ~bus.flush_i;

    assign bus.vec_valid_o   = bus.up_valid_i & issue_ok;
    assign bus.up_ready_o    = bus.vec_ready_i & issue_ok;
    assign bus.vec_insn_o    = bus.up_insn_i;
    assign bus.vec_insn_id_o = bus.up_insn_id_i;
    assign bus.vec_ctx_o     = bus.up_ctx_i;
    assign bus.flush_o       = bus.flush_i;

    assign alloc       = bus.up_valid_i & bus.up_ready_o;
    assign retire_fire = retire_valid_q & bus.retire_ready_i;
    assign head_ready  = valid_q[head_q] & done_q[head_q] & committed_q[head_q];

    // The cmt entry is the oldest speculative-range entry, so a flush squashes it instead.
    assign commit_fire = valid_q[cmt_q] & resolved_q[cmt_q] & ~committed_q[cmt_q]
                       & ~bus.flush_i;

    always_comb begin
        res_match  = '0;
        done_match = '0;
        for (int i = 0; i < Depth; i++) begin
            res_match[i]  = valid_q[i] & ~committed_q[i] & (id_q[i] == bus.resolve_id_i);
            done_match[i] = valid_q[i] & (id_q[i] == bus.done_id_i)
                          & (committed_q[i] | ~bus.flush_i);
        end
    end

    assign res_err  = bus.resolve_i & ~bus.flush_i & ~(|res_match);
    assign done_err = bus.done_i & ~(|done_match);

    // cmt == head with a committed head means every slot holds a committed entry.
    always_comb begin
        surv_cnt = {1'b0, ptr_t'(cmt_q - head_q)};
        if ((cmt_q == head_q) && valid_q[head_q] && committed_q[head_q]) begin
            surv_cnt = DepthCnt;
        end
    end

    always_comb begin
        count_d = count_q + CntW'(alloc) - CntW'(retire_fire);
        if (bus.flush_i) begin
            count_d = surv_cnt - CntW'(retire_fire);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q         <= '0;
            resolved_q      <= '0;
            committed_q     <= '0;
            done_q          <= '0;
            illegal_q       <= '0;
            for (int i = 0; i < Depth; i++) begin
                id_q[i]     <= '0;
                result_q[i] <= '0;
            end
            head_q          <= '0;
            cmt_q           <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            can_commit_q    <= 1'b0;
            can_commit_id_q <= '0;
            retire_valid_q  <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (bus.flush_i && valid_q[i] && !committed_q[i]) begin
                    valid_q[i] <= 1'b0;
                end
                if (bus.resolve_i && !bus.flush_i && res_match[i]) begin
                    resolved_q[i] <= 1'b1;
                end
                if (bus.done_i && done_match[i]) begin
                    done_q[i]    <= 1'b1;
                    illegal_q[i] <= bus.done_illegal_i;
                    result_q[i]  <= bus.done_result_i;
                end
            end

            if (commit_fire) begin
                committed_q[cmt_q] <= 1'b1;
                cmt_q              <= cmt_q + ptr_t'(1);
                can_commit_id_q    <= id_q[cmt_q];
            end
            can_commit_q <= commit_fire;

            if (retire_fire) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + ptr_t'(1);
            end
            // A fresh head needs one cycle to be evaluated, so accept forces a bubble.
            retire_valid_q <= retire_fire ? 1'b0 : head_ready;

            // Allocation never coincides with a flush, so tail has a single writer per cycle.
            if (bus.flush_i) begin
                tail_q <= cmt_q;
            end else if (alloc) begin
                valid_q[tail_q]     <= 1'b1;
                id_q[tail_q]        <= bus.up_insn_id_i;
                resolved_q[tail_q]  <= bus.up_resolved_i;
                committed_q[tail_q] <= 1'b0;
                done_q[tail_q]      <= 1'b0;
                illegal_q[tail_q]   <= 1'b0;
                tail_q              <= tail_q + ptr_t'(1);
            end
            count_q <= count_d;

            if (res_err || done_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.can_commit_o     = can_commit_q;
    assign bus.can_commit_id_o  = can_commit_id_q;
    assign bus.retire_valid_o   = retire_valid_q;
    assign bus.retire_id_o      = id_q[head_q];
    assign bus.retire_illegal_o = illegal_q[head_q];
    assign bus.retire_result_o  = result_q[head_q];
    assign bus.err_o            = err_q;

endmodule

// File: doc/rvv_commit_ctrl.md
Name: rvv_commit_ctrl

Overview:
- In-order tracking and commit controller between the scalar core's issue/commit logic and rvv_core.
- Forwards vector instructions to rvv_core and records each one in a circular outstanding table.
- Drives insn_can_commit to rvv_core in program order once an instruction is non-speculative, and handles flush of speculative entries.
- Reorders rvv_core completions (done/illegal/result) into program-order retire responses for the scalar core.

Parameters:
Depth, 4, outstanding table entries; power of two, >=2
IdWidth, 3, width of insn_id
CtxWidth, 16, width of vec_context
XLen, 64, width of scalar result

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
up_valid_i  in  1  scalar issue valid
up_ready_o  out  1  scalar issue ready
up_insn_i  in  32  instruction word
up_insn_id_i  in  IdWidth  instruction id; unique among outstanding entries
up_ctx_i  in  CtxWidth  vector context
up_resolved_i  in  1  instruction already non-speculative at issue
vec_valid_o  out  1  to rvv_core valid_i
vec_ready_i  in  1  from rvv_core ready_o
vec_insn_o  out  32  to rvv_core insn_i
vec_insn_id_o  out  IdWidth  to rvv_core insn_id_i
vec_ctx_o  out  CtxWidth  to rvv_core vec_context_i
resolve_i  in  1  scalar core: instruction became non-speculative
resolve_id_i  in  IdWidth  id being resolved
flush_i  in  1  squash all speculative instructions
flush_o  out  1  to rvv_core flush_i
can_commit_o  out  1  to rvv_core insn_can_commit_i
can_commit_id_o  out  IdWidth  to rvv_core insn_can_commit_id_i
done_i  in  1  rvv_core completion
done_id_i  in  IdWidth  completed id
done_illegal_i  in  1  completion is illegal instruction
done_result_i  in  XLen  scalar result
retire_valid_o  out  1  in-order retire to scalar core
retire_ready_i  in  1  scalar accepts retire
retire_id_o  out  IdWidth  retired id
retire_illegal_o  out  1  retired instruction illegal
retire_result_o  out  XLen  retired result
err_o  out  1  sticky protocol error

Behaviour:
- Entry fields: id, resolved, committed, done, illegal, result. Pointers head (retire), cmt (next to commit), tail (alloc), all log2(Depth) bits, wrap modulo Depth; count 0..Depth.
- Reset: all entries invalid, pointers 0, count 0, can_commit_o=0, can_commit_id_o=0, retire_valid_o=0, err_o=0.
- Issue path is combinational pass-through: vec_valid_o = up_valid_i & ~full & ~flush_i; up_ready_o = vec_ready_i & ~full & ~flush_i; vec_* data = up_* data.
- Allocate on up_valid_i & up_ready_o: write tail with resolved=up_resolved_i, other flags 0; tail++.
- Full means count==Depth, evaluated on the registered count. A same-cycle retire does not free a slot for allocation.
- Resolve: resolve_i sets resolved on the valid, uncommitted entry with matching id. If no match, ignore and set err_o.
- Commit: if the entry at cmt is valid and resolved, then next cycle can_commit_o=1 with its id, committed is set, and cmt++.
  - At most one commit pulse per cycle, strictly in order.
  - can_commit_o is registered and is a one-cycle pulse per entry.
  - Latency: resolved flag visible at cycle t gives the pulse at cycle t+1.
- Completion: done_i sets done/illegal/result on the valid entry with matching id. If no match (including a flushed id), ignore and set err_o.
- Retire:
  - retire_valid_o is a registered view of "head valid & done"; retire_* data comes from the head entry.
  - On retire_valid_o & retire_ready_i: free the head, head++.
  - Done-to-retire latency is at least 1 cycle. retire_valid_o holds with stable data until accepted.
  - A retired entry must already be committed. If done arrives for an uncommitted entry, store it; it retires only after commit.
- Flush:
  - flush_o = flush_i, combinational.
  - On flush_i, invalidate every entry from cmt to tail-1 and set tail=cmt; count becomes (cmt-head) mod Depth, or Depth when committed entries fill the table.
  - Committed entries are kept and still retire. A pending can_commit pulse already registered still fires.
  - No allocation, and no resolve takes effect, in a flush cycle. Done for a surviving entry in a flush cycle is applied.
- Simultaneous events in one cycle: alloc + resolve of another id + done + retire + commit are all legal. Resolve and done of the same entry are both applied.
- err_o clears only on reset.

Test Plan:
- Issue ids 1,2,3 with up_resolved_i=1, rvv_core done in order 1,2,3 -> can_commit pulses 1,2,3 on consecutive cycles; retire 1,2,3 in order, illegal=0, results match.
- Issue ids 0..3 unresolved (Depth=4) -> 5th issue sees up_ready_o=0. Resolve 2 first -> no commit pulse. Resolve 0 -> pulse 0 only. Resolve 1 -> pulses 1, then 2.
- Completions out of order 3,1,0,2 with results 0x30,0x10,0x00,0x20 -> retire order 0,1,2,3 with matching results; retire_ready_i=0 for 3 cycles -> retire outputs held stable.
- Ids 4,5,6 issued, 4 committed, flush_i -> flush_o pulses; 5 and 6 are dropped; a later done for id 5 sets err_o; id 4 retires; next issued id is allocated at the old cmt slot.
- Done with illegal=1 for id 2 -> retire_illegal_o=1 for id 2 only.
- Assert rst_ni low with 3 outstanding entries -> all outputs return to reset values immediately; the first issue after reset is allocated at slot 0.
